scan_dump_ctrl: RTL and testbench

Sequencer for the CSoC scan-based state-dump test.
- On `start_i` it holds the CSoC in test mode and shifts the whole scan chain out one bit per `csoc_clk_o` pulse, streaming each bit to the UART transmitter as ASCII `H`/`L`.
- It then releases scan enable and runs the core for a fixed number of functional clocks, and dumps the chain a second time.
- It sits between the UART command parser (which issues `start_i`), the UART TX, and the CSoC test pins.

---
 rtl/scan_dump_ctrl_pkg.sv | 21 ++
 rtl/scan_dump_ctrl_pulser.sv | 51 +++++
 rtl/scan_dump_ctrl.sv | 166 ++++++++++++++++
 tb/tb_scan_dump_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_dump_ctrl_pkg.sv
// Shared types and constants for the CSoC scan-dump sequencer.
// No logic here; the state encoding and ASCII codes are used by the top.
// No handshakes.
package scan_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        SEND,
        SHIFT_HI,
        SHIFT_LO,
        EOL,
        RUN,
        DONE
    } state_t;

    localparam logic [7:0] CH_H  = 8'h48;
    localparam logic [7:0] CH_L  = 8'h4C;
    localparam logic [7:0] CH_NL = 8'h0A;

endpackage

// File: rtl/scan_dump_ctrl_pulser.sv
// Purpose: one CSoC clock period per go strobe, HALF_PER cycles high then HALF_PER low.
// Latency: pclk_o rises the cycle after go; done_o marks the last low cycle.
// Backpressure: go is honoured when idle or on the done_o cycle (back-to-back periods).
module csoc_clk_pulser #(
    parameter int HALF_PER = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic go,
    output logic pclk_o,
    output logic fall_o,
    output logic done_o
);

    localparam int HW = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;
    localparam logic [HW-1:0] LAST_CNT = HW'(HALF_PER - 1);

    logic          active;
    logic [HW-1:0] cnt;
    logic          last_cyc;

    assign last_cyc = (cnt == LAST_CNT);
    // fall_o: final high cycle; done_o: final low cycle of the period.
    assign fall_o   = active && pclk_o && last_cyc;
    assign done_o   = active && !pclk_o && last_cyc;

    // Phase counter; pclk_o is a flop so the CSoC clock never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= 1'b0;
            pclk_o <= 1'b0;
            cnt    <= '0;
        end else if (go && (!active || done_o)) begin
            active <= 1'b1;
            pclk_o <= 1'b1;
            cnt    <= '0;
        end else if (active) begin
            if (last_cyc) begin
                cnt <= '0;
                if (pclk_o) begin
                    pclk_o <= 1'b0;
                end else begin
                    active <= 1'b0;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/scan_dump_ctrl.sv
// Purpose: dump the CSoC scan chain as ASCII H/L over UART, run the core, dump again.
// Latency: first tx_start_o two cycles after start_i; per bit 1 + >=1 + 2*HALF_PER cycles.
// Backpressure: stalls in SEND/EOL until tx_ready_i; start_i ignored while busy.
module scan_dump_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter int NUM_REGS  = 1919,
    parameter int RUN_TICKS = 6,
    parameter int MAX_COL   = 64,
    parameter int HALF_PER  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       tx_start_o,
    output logic [7:0] tx_data_o,
    input  logic       tx_ready_i,
    input  logic       scan_out_i,
    output logic       csoc_clk_o,
    output logic       csoc_rstn_o,
    output logic       csoc_test_se_o,
    output logic       csoc_test_tm_o
);

    localparam int BW = $clog2(NUM_REGS + 1);
    localparam int CW = $clog2(MAX_COL + 1);
    localparam int RW = $clog2(RUN_TICKS + 1);

    localparam logic [BW-1:0] LAST_BIT  = BW'(NUM_REGS - 1);
    localparam logic [CW-1:0] LAST_COL  = CW'(MAX_COL - 1);
    localparam logic [RW-1:0] LAST_TICK = RW'(RUN_TICKS - 1);

    state_t        state;
    logic          phase;     // 0: first dump, 1: second dump
    logic          last;      // pending newline closes the dump
    logic [BW-1:0] bit_cnt;
    logic [CW-1:0] col;
    logic [RW-1:0] run_cnt;

    logic pls_go;
    logic pls_fall;
    logic pls_done;

    csoc_clk_pulser #(
        .HALF_PER (HALF_PER)
    ) u_pulser (
        .clk    (clk),
        .rst    (rst),
        .go     (pls_go),
        .pclk_o (csoc_clk_o),
        .fall_o (pls_fall),
        .done_o (pls_done)
    );

    // Launch a clock period on the edge that enters SHIFT_HI or RUN, and chain RUN periods.
    always_comb begin
        pls_go = 1'b0;
        case (state)
            SEND:    pls_go = tx_ready_i;
            EOL:     pls_go = tx_ready_i && last && !phase;
            RUN:     pls_go = pls_done && (run_cnt != LAST_TICK);
            default: pls_go = 1'b0;
        endcase
    end

    // The strobe coincides with the accepting cycle so the first byte leaves two cycles after start.
    assign tx_start_o = tx_ready_i && ((state == SEND) || (state == EOL));

    // Sequencer: sample, send, shift per bit; newline per line; functional run between dumps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            phase          <= 1'b0;
            last           <= 1'b0;
            bit_cnt        <= '0;
            col            <= '0;
            run_cnt        <= '0;
            tx_data_o      <= 8'h00;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            csoc_rstn_o    <= 1'b0;
            csoc_test_se_o <= 1'b1;
            csoc_test_tm_o <= 1'b1;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        state       <= SAMPLE;
                        phase       <= 1'b0;
                        bit_cnt     <= '0;
                        col         <= '0;
                        busy_o      <= 1'b1;
                        done_o      <= 1'b0;
                        csoc_rstn_o <= 1'b1;
                    end
                end
                SAMPLE: begin
                    tx_data_o <= scan_out_i ? CH_H : CH_L;
                    state     <= SEND;
                end
                SEND: begin
                    if (tx_ready_i) begin
                        state <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    if (pls_fall) begin
                        state <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (pls_done) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        col     <= col + 1'b1;
                        // Last bit takes priority so a coincident line end gives one newline.
                        if (bit_cnt == LAST_BIT) begin
                            last      <= 1'b1;
                            tx_data_o <= CH_NL;
                            state     <= EOL;
                        end else if (col == LAST_COL) begin
                            last      <= 1'b0;
                            tx_data_o <= CH_NL;
                            state     <= EOL;
                        end else begin
                            state <= SAMPLE;
                        end
                    end
                end
                EOL: begin
                    if (tx_ready_i) begin
                        col <= '0;
                        if (!last) begin
                            state <= SAMPLE;
                        end else if (!phase) begin
                            state          <= RUN;
                            bit_cnt        <= '0;
                            run_cnt        <= '0;
                            csoc_test_se_o <= 1'b0;
                            csoc_test_tm_o <= 1'b0;
                        end else begin
                            state  <= DONE;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (pls_done) begin
                        if (run_cnt == LAST_TICK) begin
                            state          <= SAMPLE;
                            phase          <= 1'b1;
                            csoc_test_se_o <= 1'b1;
                            csoc_test_tm_o <= 1'b1;
                        end else begin
                            run_cnt <= run_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scan_dump_ctrl.sv
// Purpose: directed + randomized checks of scan_dump_ctrl against a stream-level reference.
// Latency: free-running clk, 10 ns period.
// Backpressure: TX model drops ready for 10 cycles per strobe; optional long hold.
module tb_scan_dump_ctrl;

    localparam int N  = 5;
    localparam int RT = 3;
    localparam int HP = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_i = 1'b0;
    logic tx_hold = 1'b0;

    // Main DUT (MAX_COL=2)
    logic       busy, done, tx_start, tx_rdy, scan_out, cclk, crstn, se, tm;
    logic [7:0] tx_data;
    // Second DUT (MAX_COL=5)
    logic       busy5, done5, tx_start5, tx_rdy5, scan_out5, cclk5, crstn5, se5, tm5;
    logic [7:0] tx_data5;

    always #5 clk = ~clk;

    scan_dump_ctrl #(.NUM_REGS(N), .RUN_TICKS(RT), .MAX_COL(2), .HALF_PER(HP)) u_dut (
        .clk(clk), .rst(rst), .start_i(start_i), .busy_o(busy), .done_o(done),
        .tx_start_o(tx_start), .tx_data_o(tx_data), .tx_ready_i(tx_rdy),
        .scan_out_i(scan_out), .csoc_clk_o(cclk), .csoc_rstn_o(crstn),
        .csoc_test_se_o(se), .csoc_test_tm_o(tm)
    );

    scan_dump_ctrl #(.NUM_REGS(N), .RUN_TICKS(RT), .MAX_COL(5), .HALF_PER(HP)) u_dut5 (
        .clk(clk), .rst(rst), .start_i(start_i), .busy_o(busy5), .done_o(done5),
        .tx_start_o(tx_start5), .tx_data_o(tx_data5), .tx_ready_i(tx_rdy5),
        .scan_out_i(scan_out5), .csoc_clk_o(cclk5), .csoc_rstn_o(crstn5),
        .csoc_test_se_o(se5), .csoc_test_tm_o(tm5)
    );

    // Scan contents for dump 1 (p0) and what the core leaves behind after the run (p1).
    logic [4:0] p0 = 5'b0;
    logic [4:0] p1 = 5'b0;

    // TX models: ready low for a fixed number of cycles after each accepted strobe.
    int tx_cnt = 0;
    int tx_cnt5 = 0;
    assign tx_rdy  = (tx_cnt == 0) && !tx_hold;
    assign tx_rdy5 = (tx_cnt5 == 0);
    always @(posedge clk) begin
        if (tx_start && tx_rdy) tx_cnt <= 10;
        else if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
        if (tx_start5 && tx_rdy5) tx_cnt5 <= 3;
        else if (tx_cnt5 > 0) tx_cnt5 <= tx_cnt5 - 1;
    end

    // Scan chain models: shift toward bit 0 in test mode, load p1 on functional clocks.
    logic [4:0] chain = 5'b0;
    logic [4:0] chain5 = 5'b0;
    assign scan_out  = chain[0];
    assign scan_out5 = chain5[0];

    // Observed stream and activity counters for the current run.
    logic [255:0] rx_vec = '0;
    logic [255:0] rx5_vec = '0;
    int rx_len = 0, rx5_len = 0;
    int rises = 0, se_low = 0, rise_se_low = 0, se_tm_mis = 0, dbl = 0;
    logic prev_cclk = 1'b0, prev_cclk5 = 1'b0, prev_strobe = 1'b0;

    always @(negedge clk) begin
        if (start_i && !busy) begin
            chain <= p0; rx_vec <= '0; rx_len <= 0; rises <= 0; se_low <= 0;
            rise_se_low <= 0; se_tm_mis <= 0; dbl <= 0; prev_strobe <= 1'b0;
            prev_cclk <= cclk;
        end else begin
            prev_cclk   <= cclk;
            prev_strobe <= tx_start;
            if (tx_start) begin
                rx_vec <= {rx_vec[247:0], tx_data};
                rx_len <= rx_len + 1;
                if (prev_strobe) dbl <= dbl + 1;
            end
            if (cclk && !prev_cclk) begin
                rises <= rises + 1;
                if (!se) rise_se_low <= rise_se_low + 1;
                chain <= se ? {1'b0, chain[4:1]} : p1;
            end
            if (!se) se_low <= se_low + 1;
            if (se !== tm) se_tm_mis <= se_tm_mis + 1;
        end
    end

    always @(negedge clk) begin
        if (start_i && !busy5) begin
            chain5 <= p0; rx5_vec <= '0; rx5_len <= 0; prev_cclk5 <= cclk5;
        end else begin
            prev_cclk5 <= cclk5;
            if (tx_start5) begin
                rx5_vec <= {rx5_vec[247:0], tx_data5};
                rx5_len <= rx5_len + 1;
            end
            if (cclk5 && !prev_cclk5) chain5 <= se5 ? {1'b0, chain5[4:1]} : p1;
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: both dumps as characters, newline every mc characters and at dump end.
    task automatic build_exp(input int mc, output logic [255:0] v, output int len);
        logic [4:0] p;
        int c;
        v = '0;
        len = 0;
        for (int d = 0; d < 2; d++) begin
            p = (d == 0) ? p0 : p1;
            c = 0;
            for (int i = 0; i < N; i++) begin
                v = {v[247:0], (p[i] ? 8'h48 : 8'h4C)};
                len++;
                c++;
                if (i == N - 1 || c == mc) begin
                    v = {v[247:0], 8'h0A};
                    len++;
                    c = 0;
                end
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int i;
        i = 0;
        while (!(done && done5) && i < 3000) begin
            @(negedge clk);
            i++;
        end
        chk({tag, "_done_wait"}, int'(done && done5), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tx_start"}, int'(tx_start), 0);
        chk({tag, "_tx_data"},  int'(tx_data), 0);
        chk({tag, "_cclk"},     int'(cclk), 0);
        chk({tag, "_rstn"},     int'(crstn), 0);
        chk({tag, "_se"},       int'(se), 1);
        chk({tag, "_tm"},       int'(tm), 1);
        chk({tag, "_busy"},     int'(busy), 0);
        chk({tag, "_done"},     int'(done), 0);
    endtask

    task automatic check_run(input string tag);
        logic [255:0] ev;
        int el;
        build_exp(2, ev, el);
        chkv({tag, "_stream"}, rx_vec, ev);
        chk({tag, "_len"}, rx_len, el);
        build_exp(5, ev, el);
        chkv({tag, "_stream5"}, rx5_vec, ev);
        chk({tag, "_len5"}, rx5_len, el);
        chk({tag, "_rises"}, rises, 2 * N + RT);
        chk({tag, "_se_low_cycles"}, se_low, 2 * HP * RT);
        chk({tag, "_run_rises"}, rise_se_low, RT);
        chk({tag, "_se_tm_agree"}, se_tm_mis, 0);
        chk({tag, "_dbl_strobe"}, dbl, 0);
        chk({tag, "_done_o"}, int'(done), 1);
        chk({tag, "_busy_o"}, int'(busy), 0);
        chk({tag, "_rstn_after"}, int'(crstn), 1);
        chk({tag, "_se_after"}, int'(se), 1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_rstn", int'(crstn), 0);
        chk("idle_busy", int'(busy), 0);

        // Directed pattern 1,0,1,1,0 in both dumps; first-strobe latency
        p0 = 5'b01101;
        p1 = 5'b01101;
        pulse_start();
        @(negedge clk);
        chk("lat_sample_strobe", int'(tx_start), 0);
        chk("lat_busy", int'(busy), 1);
        chk("lat_rstn", int'(crstn), 1);
        @(negedge clk);
        chk("lat_send_strobe", int'(tx_start), 1);
        chk("lat_send_data", int'(tx_data), 8'h48);
        wait_done("dir");
        check_run("dir");

        // Random patterns, restarted from DONE, with start pulses while busy
        for (int r = 0; r < 3; r++) begin
            p0 = 5'($urandom_range(31, 0));
            p1 = 5'($urandom_range(31, 0));
            pulse_start();
            repeat (20 + $urandom_range(150, 0)) @(negedge clk);
            pulse_start();
            repeat ($urandom_range(60, 5)) @(negedge clk);
            pulse_start();
            wait_done("rnd");
            check_run("rnd");
        end

        // TX held not-ready for 200 cycles during the first SEND
        p0 = 5'($urandom_range(31, 0));
        p1 = 5'($urandom_range(31, 0));
        @(posedge clk); #1 start_i = 1'b1; tx_hold = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        repeat (200) @(negedge clk);
        chk("hold_no_rise", rises, 0);
        chk("hold_no_strobe", rx_len, 0);
        chk("hold_cclk_low", int'(cclk), 0);
        chk("hold_busy", int'(busy), 1);
        @(posedge clk); #1 tx_hold = 1'b0;
        repeat (3) @(negedge clk);
        chk("hold_one_strobe", rx_len, 1);
        wait_done("hold");
        check_run("hold");

        // Reset in the middle of the second dump, then a full replay
        p0 = 5'($urandom_range(31, 0));
        p1 = 5'($urandom_range(31, 0));
        pulse_start();
        begin
            int i;
            i = 0;
            while (rx_len < 10 && i < 3000) begin
                @(negedge clk);
                i++;
            end
            chk("mid_dump2_reached", int'(rx_len >= 10), 1);
        end
        @(posedge clk); #1 rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        repeat (3) @(negedge clk);
        check_reset_outputs("held_rst");
        @(posedge clk); #1 rst = 1'b0;
        p0 = 5'($urandom_range(31, 0));
        p1 = 5'($urandom_range(31, 0));
        pulse_start();
        wait_done("replay");
        check_run("replay");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
